// File: rtl/shift64_assembler.sv
// Purpose: packs 1-bit or 8-bit chunks, shifted in either direction, into 64-bit words on a valid/ready port.
// Latency: out_valid rises the cycle after the chunk that completes the word is accepted.
// Backpressure: in_ready drops while a finished word waits (out_valid && !out_ready); chunks stall upstream.
module shift64_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wide,
    input  logic        in_dir,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        err
);

    logic [63:0] sr;
    logic [6:0]  cnt;
    logic        dir_q;

    logic        accept;
    logic        eff_dir;
    logic        overflow;
    logic        complete;
    logic [6:0]  step_sz;
    logic [6:0]  cnt_sum;
    logic [63:0] sr_next;

    // A pending word blocks new chunks only while the consumer is not taking it.
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // The first chunk of a word chooses the direction; later chunks follow the latched one.
    assign eff_dir  = (cnt == 7'd0) ? in_dir : dir_q;
    assign step_sz  = in_wide ? 7'd8 : 7'd1;
    assign cnt_sum  = cnt + step_sz;

    // A byte that does not fit in the remaining space is swallowed and flagged.
    assign overflow = in_wide && (cnt > 7'd56);
    assign complete = !overflow && (cnt_sum == 7'd64);

    // Next assembly value for the chunk on the input, in the effective direction.
    always_comb begin
        sr_next = sr;
        case ({eff_dir, in_wide})
            2'b00:   sr_next = {sr[62:0], in_data[0]};
            2'b01:   sr_next = {sr[55:0], in_data[7:0]};
            2'b10:   sr_next = {in_data[0], sr[63:1]};
            default: sr_next = {in_data[7:0], sr[63:8]};
        endcase
    end

    // Assembly state, sticky error and the registered output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr        <= '0;
            cnt       <= '0;
            dir_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            // Consumer took the word; a completion below may re-raise it in the same edge.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (flush) begin
                sr  <= '0;
                cnt <= '0;
                err <= 1'b0;
            end else if (accept) begin
                if (cnt == 7'd0) begin
                    dir_q <= in_dir;
                end
                if (overflow) begin
                    err <= 1'b1;
                end else if (complete) begin
                    out_data  <= sr_next;
                    out_valid <= 1'b1;
                    sr        <= '0;
                    cnt       <= '0;
                end else begin
                    sr  <= sr_next;
                    cnt <= cnt_sum;
                end
            end
        end
    end

endmodule

// File: doc/shift64_assembler.md
Name: shift64_assembler

Overview:
- Receive side of the 64-bit shift datapath. It accepts 1-bit or 8-bit chunks, which are the same granularities the 64-bit shifter moves data in.
- Chunks are shifted into a 64-bit assembly register in either direction.
- Each completed 64-bit word is presented on a valid/ready output port.
- It sits between a narrow serial/byte source and any consumer of full 64-bit words.

Parameters:
- none (width fixed at 64 data bits, 7-bit fill counter)

Ports:
- clk        input   1   system clock, all state updates on rising edge
- reset      input   1   synchronous, active-high reset
- flush      input   1   discard partial word and clear err (synchronous)
- in_valid   input   1   chunk present on in_data
- in_ready   output  1   block can accept a chunk this cycle
- in_wide    input   1   0 = 1-bit chunk (in_data[0]), 1 = 8-bit chunk (in_data[7:0])
- in_dir     input   1   0 = shift-left entry (first chunk ends at MSB), 1 = shift-right entry (first chunk ends at LSB)
- in_data    input   8   chunk data
- out_valid  output  1   out_data holds a completed word
- out_ready  input   1   consumer takes out_data this cycle
- out_data   output  64  completed word
- err        output  1   sticky: wide chunk dropped because it would overflow the word

Behaviour:
- Reset (reset=1 at an edge):
  - assembly reg sr=0, fill count cnt=0, latched direction dir_q=0.
  - out_valid=0, out_data=0, err=0.
  - reset has priority over every other input, including mid-word and while an output is pending.
- Acceptance:
  - in_ready = !(out_valid && !out_ready); combinational, not dependent on in_wide.
  - A chunk is accepted when in_valid && in_ready && !flush.
- Direction latch:
  - On an accepted chunk with cnt==0, dir_q <= in_dir, and that chunk uses in_dir.
  - Later chunks of the same word use dir_q; in_dir is ignored until the next word.
- Shift on accept, with d = effective direction:
  - d=0, narrow: sr <= {sr[62:0], in_data[0]}
  - d=0, wide: sr <= {sr[55:0], in_data[7:0]}
  - d=1, narrow: sr <= {in_data[0], sr[63:1]}
  - d=1, wide: sr <= {in_data[7:0], sr[63:8]}
  - cnt increases by 1 (narrow) or 8 (wide).
- Overflow:
  - A wide chunk accepted while cnt>56 is consumed (handshake completes) but discarded.
  - sr and cnt are unchanged; err <= 1 and stays set until reset or flush.
- Completion:
  - When an accepted chunk makes cnt+step == 64, then at that same edge: out_data <= new sr value, out_valid <= 1, cnt <= 0, sr <= 0.
  - Latency: out_valid is high the cycle after the completing chunk is accepted.
- Output handshake:
  - out_data is held stable while out_valid && !out_ready.
  - out_valid falls after an edge with out_ready=1, unless a new word completes at that same edge, in which case out_valid stays 1 and out_data takes the new word.
  - Back-to-back words have no bubble when out_ready is held high.
- Flush:
  - Takes effect at an edge with flush=1: cnt <= 0, sr <= 0, err <= 0.
  - Any chunk offered in that cycle is not accepted.
  - A pending output word (out_valid, out_data) is untouched, and the output handshake proceeds normally.
- Mixed chunk sizes within a word are legal; only the bit total matters.

Test Plan:
- Wide, left: reset; 8 wide chunks 0x01..0x08 with in_dir=0, out_ready=1 -> out_valid=1 one cycle after the 8th accept, out_data=0x0102030405060708.
- Wide, right: same 8 chunks with in_dir=1 on the first chunk -> out_data=0x0807060504030201. Also repeat the word with in_dir toggled on chunks 2..8 -> result unchanged (dir_q holds).
- Narrow: 64 narrow chunks alternating 1,0 (first=1), in_dir=0 -> out_data=0xAAAAAAAAAAAAAAAA. Then 4 wide 0xFF plus 32 narrow 0s, in_dir=0 -> out_data=0xFFFFFFFF00000000.
- Backpressure: complete a word with out_ready=0 -> in_ready=0 and out_data held for 10 cycles. Raise out_ready -> in_ready=1 same cycle; a word completing at that same edge keeps out_valid=1 with the new data.
- Overflow: 57 narrow 1s, then a wide 0x00 -> accepted, err=1, no word produced. Then 7 narrow 1s -> out_data=0xFFFFFFFFFFFFFFFF, err still 1. Then flush -> err=0.
- Reset/flush mid-word: 3 wide chunks, then assert reset (or flush) one cycle -> out_valid=0. Then 8 wide 0x11 -> out_data=0x1111111111111111, with no trace of the earlier chunks.
